// File: rtl/bram_byte_bank_responder_if.sv
// Request/response bundle between the memory stage and the byte-bank responder.
// The master drives requests and accepts responses; the slave is the responder.
interface bram_byte_bank_responder_if #(
    parameter int ADDR_WIDTH = 19
);
    logic                  req_valid;
    logic                  req_ready;
    logic [4:0]            req_access_code;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [31:0]           req_store_data;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_data;
    logic                  resp_is_store;

    modport master (
        output req_valid, req_access_code, req_address, req_store_data, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_is_store
    );

    modport slave (
        input  req_valid, req_access_code, req_address, req_store_data, resp_ready,
        output req_ready, resp_valid, resp_data, resp_is_store
    );
endinterface

// File: rtl/bram_byte_bank_responder.sv
// Four byte-wide BRAM banks serving misaligned loads/stores, one request at a time.
// Store response 1 cycle after accept, load 2; response held until resp_ready, no new request meanwhile.
module bram_byte_bank_responder #(
    parameter int ADDR_WIDTH = 19,
    parameter int ROW_WIDTH  = 17
) (
    input  logic                        clk,
    input  logic                        resetn,
    bram_byte_bank_responder_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, next_state;

    logic                      accept;
    logic                      is_store;
    logic [1:0]                rot;
    logic [3:0]                be;
    logic [ROW_WIDTH-1:0]      row;
    logic [ROW_WIDTH-1:0]      row_next;
    logic [1:0]                rot_q;
    logic [3:0]                be_q;
    logic [3:0][ROW_WIDTH-1:0] bank_row;
    logic [3:0][7:0]           bank_wdat;
    logic [3:0]                bank_we;
    logic [3:0][7:0]           bank_q;
    logic [31:0]               lane_dat;
    logic [31:0]               resp_data_q;
    logic                      resp_is_store_q;

    assign is_store = bus.req_access_code[0];
    assign be       = bus.req_access_code[4:1];
    assign rot      = bus.req_address[1:0];
    assign row      = bus.req_address[ADDR_WIDTH-1:2];
    assign row_next = row + ROW_WIDTH'(1);
    assign accept   = resetn && (state == IDLE) && bus.req_valid;

    // Bank b holds lane (b - rot); banks below the start offset belong to the next row.
    always_comb begin
        bank_row  = '0;
        bank_wdat = '0;
        bank_we   = '0;
        for (int b = 0; b < 4; b++) begin
            logic [1:0] lane;
            logic [1:0] byte_sel;
            lane         = 2'(b) - rot;
            byte_sel     = ~lane;
            bank_row[b]  = (2'(b) >= rot) ? row : row_next;
            bank_wdat[b] = bus.req_store_data[{byte_sel, 3'b000} +: 8];
            bank_we[b]   = accept && is_store && be[byte_sel];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bank
        logic [7:0] mem [2**ROW_WIDTH];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (bank_we[g]) begin
                mem[bank_row[g]] <= bank_wdat[g];
            end
            if (accept && !is_store) begin
                rd_q <= mem[bank_row[g]];
            end
        end

        assign bank_q[g] = rd_q;
    end

    always_comb begin
        lane_dat = '0;
        for (int i = 0; i < 4; i++) begin
            if (be_q[3-i]) begin
                lane_dat[8*(3-i) +: 8] = bank_q[rot_q + 2'(i)];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.req_valid) next_state = is_store ? RESP : READ;
            READ:    next_state = RESP;
            RESP:    if (bus.resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            rot_q           <= '0;
            be_q            <= '0;
            resp_data_q     <= '0;
            resp_is_store_q <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                rot_q <= rot;
                be_q  <= be;
                if (is_store) begin
                    resp_data_q     <= '0;
                    resp_is_store_q <= 1'b1;
                end
            end
            if (state == READ) begin
                resp_data_q     <= lane_dat;
                resp_is_store_q <= 1'b0;
            end
        end
    end

    assign bus.req_ready     = resetn && (state == IDLE);
    assign bus.resp_valid    = (state == RESP);
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_is_store = resp_is_store_q;
endmodule

// File: doc/bram_byte_bank_responder.md
Name: bram_byte_bank_responder

Overview:
- Memory-side responder for the load/store path.
- Owns four byte-wide synchronous BRAM banks and accepts one load or store request at a time from the memory stage.
- Handles misaligned accesses by writing or reading each byte in its own bank, then reassembling bytes into register lane order.
- Returns a response over a valid/ready handshake to the memory/writeback pipeline register.

Parameters:
- ADDR_WIDTH, 19: byte-address width. Total capacity is 2^ADDR_WIDTH bytes.
- ROW_WIDTH, 17: per-bank row-address width. Must equal ADDR_WIDTH-2. Each bank is 2^ROW_WIDTH x 8 bits.

Ports:
- clk  input  1  single clock; all logic is on the rising edge.
- resetn  input  1  reset, synchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_access_code  input  5  bit0: 1=store, 0=load. Bits[4:1]: byte-enable be[3:0].
- req_address  input  ADDR_WIDTH  byte address A; any alignment is allowed.
- req_store_data  input  32  store data in lane order.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  32  load data in lane order; 0 for stores.
- resp_is_store  output  1  response belongs to a store.

Behaviour:
- Lane mapping:
  - Lane i (i=0..3) is data[31-8i:24-8i], enabled by be[3-i].
  - Byte address of lane i: Ai = (A+i) mod 2^ADDR_WIDTH.
  - Ai lives in bank Ai[1:0], row Ai[ADDR_WIDTH-1:2].
  - A misaligned access touches row R for lower banks and row R+1 for the wrapped banks. R+1 wraps from 2^ROW_WIDTH-1 to 0.
- Reset (resetn=0 at a rising edge):
  - State returns to IDLE.
  - req_ready=0 during reset and 1 in the first IDLE cycle after reset.
  - resp_valid=0, resp_data=0, resp_is_store=0.
  - A store presented on a reset edge is not written.
  - BRAM contents are not cleared.
- States:
  - IDLE: req_ready=1. On req_valid:
    - Store: at the same edge, write every enabled lane to its bank/row. Disabled lanes are untouched. Register resp_data=0 and resp_is_store=1, then go to RESP.
    - Load: at the same edge, present all four bank read addresses; each bank registers its byte. Capture r=A[1:0] and be. Go to READ.
  - READ: req_ready=0. Rotate bank outputs into lanes: lane i takes bank (r+i) mod 4. Lanes with be[3-i]=0 are forced to 0. Register resp_data, set resp_is_store=0, go to RESP.
  - RESP: resp_valid=1, and resp_data/resp_is_store are held stable. On resp_ready, return to IDLE. resp_valid drops on the next cycle.
- Latency and throughput:
  - Store: resp_valid rises one cycle after acceptance.
  - Load: resp_valid rises two cycles after acceptance.
  - Minimum spacing between accepted requests is 2 cycles for stores and 3 cycles for loads.
- Boundary cases:
  - be=0000: the request is accepted, nothing is written, and a load returns 0. A response is still produced.
  - Non-contiguous be masks are legal; each lane is handled independently.
  - Store then load to the same address in consecutive requests: the load observes the stored data, since the write completes before the load's read edge.
  - Reset asserted in READ or RESP abandons the response without retry.
  - req_* inputs are ignored outside IDLE.

Test Plan:
- Aligned word: store A=0x10, code=5'b11111, data 0xDEADBEEF, then load A=0x10, be=1111.
  -> Store response after 1 cycle. Load resp_data=0xDEADBEEF after 2 cycles. Bank0 row4=0xDE, bank3 row4=0xEF.
- Misaligned word: store 0x11223344 at A=0x7, then load A=0x7.
  -> Bank3 row1=0x11; banks0/1/2 row2=0x22/0x33/0x44. Load returns 0x11223344.
- Partial lanes: preload word 0xAAAAAAAA at A=0x20, then store be=0100 with data 0x00550000 at A=0x20, then load be=1111.
  -> Load returns 0xAA55AAAA. Load with be=0001 returns 0x000000AA.
- Top wrap: store word 0xCAFEF00D at A=0x7FFFE, then load the same address.
  -> Bytes land at 0x7FFFE, 0x7FFFF, 0x00000, 0x00001. Load returns 0xCAFEF00D.
- Backpressure: hold resp_ready=0 for 5 cycles after a load.
  -> resp_valid and resp_data stay stable, and req_ready=0 throughout. After resp_ready=1, next-cycle resp_valid=0 and req_ready=1.
- Reset mid-operation and be=0000:
  - Assert resetn=0 while in READ -> all outputs zero next cycle, IDLE.
  - Store with be=0000 at a written address -> memory unchanged on readback, and a response is still generated.
